// File: rtl/prim_pixel_writer.sv
// Pixel back end: clips an (x,y) stream, maps each pixel to a VRAM word/nibble-mask/data
// for 4 or 8 bpp, and queues the writes in front of the VRAM arbiter.
module prim_pixel_writer #(
  parameter int CORDW      = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 16,
  parameter int RST_CLIP_W = 320,
  parameter int RST_CLIP_H = 240,
  parameter int RST_STRIDE = 160
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic [15:0]             cmd_i,
  input  logic                    cmd_valid_i,
  input  logic                    pix_valid_i,
  output logic                    pix_ready_o,
  input  logic signed [CORDW-1:0] pix_x_i,
  input  logic signed [CORDW-1:0] pix_y_i,
  input  logic                    pix_last_i,
  output logic                    vram_sel_o,
  output logic                    vram_wr_o,
  output logic [3:0]              vram_mask_o,
  output logic [ADDR_W-1:0]       vram_addr_o,
  output logic [15:0]             vram_data_o,
  input  logic                    vram_ack_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [15:0]             clip_count_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [3:0] {
    OP_CLIP_X0   = 4'd0,
    OP_CLIP_Y0   = 4'd1,
    OP_CLIP_X1   = 4'd2,
    OP_CLIP_Y1   = 4'd3,
    OP_COLOR     = 4'd4,
    OP_STRIDE    = 4'd5,
    OP_BASE_LO   = 4'd6,
    OP_BASE_HI   = 4'd7,
    OP_MODE      = 4'd8,
    OP_CLR_STATS = 4'd9
  } opcode_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        mask;
    logic [15:0]       data;
  } wr_entry_t;

  // Configuration
  logic signed [CORDW-1:0] r_clip_x0, r_clip_y0, r_clip_x1, r_clip_y1;
  logic [7:0]              r_color;
  logic [11:0]             r_stride;
  logic [15:0]             r_base;
  logic                    r_mode8;

  opcode_e                 w_op;
  logic signed [CORDW-1:0] w_payload_s;

  assign w_op        = opcode_e'(cmd_i[15:12]);
  assign w_payload_s = CORDW'($signed(cmd_i[11:0]));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make results depend on block ordering.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_clip_x0 <= '0;
      r_clip_y0 <= '0;
      r_clip_x1 <= CORDW'(RST_CLIP_W - 1);
      r_clip_y1 <= CORDW'(RST_CLIP_H - 1);
      r_color   <= '0;
      r_stride  <= 12'(RST_STRIDE);
      r_base    <= '0;
      r_mode8   <= 1'b1;
    end else if (cmd_valid_i) begin
      case (w_op)
        OP_CLIP_X0: r_clip_x0    <= w_payload_s;
        OP_CLIP_Y0: r_clip_y0    <= w_payload_s;
        OP_CLIP_X1: r_clip_x1    <= w_payload_s;
        OP_CLIP_Y1: r_clip_y1    <= w_payload_s;
        OP_COLOR:   r_color      <= cmd_i[7:0];
        OP_STRIDE:  r_stride     <= cmd_i[11:0];
        OP_BASE_LO: r_base[7:0]  <= cmd_i[7:0];
        OP_BASE_HI: r_base[15:8] <= cmd_i[7:0];
        OP_MODE:    r_mode8      <= cmd_i[0];
        default:    ;
      endcase
    end
  end

  // Stage 0: clip test and address/mask/data mapping in the acceptance cycle
  logic                w_in;
  logic [CORDW-1:0]    w_x_u, w_y_u;
  logic [ADDR_W-1:0]   w_row, w_col;
  wr_entry_t           w_s0_entry;
  logic                w_accept;

  assign w_in  = (pix_x_i >= r_clip_x0) && (pix_x_i <= r_clip_x1) &&
                 (pix_y_i >= r_clip_y0) && (pix_y_i <= r_clip_y1);
  assign w_x_u = $unsigned(pix_x_i);
  assign w_y_u = $unsigned(pix_y_i);
  assign w_row = ADDR_W'(w_y_u) * ADDR_W'(r_stride);
  assign w_col = r_mode8 ? ADDR_W'(w_x_u >> 1) : ADDR_W'(w_x_u >> 2);

  assign w_s0_entry.addr = ADDR_W'(r_base) + w_row + w_col;
  assign w_s0_entry.mask = r_mode8 ? (w_x_u[0] ? 4'b0011 : 4'b1100) : (4'b1000 >> w_x_u[1:0]);
  assign w_s0_entry.data = r_mode8 ? {r_color, r_color} : {4{r_color[3:0]}};
  assign w_accept        = pix_valid_i && pix_ready_o;

  // Stage 1
  logic      r_s1_valid, r_s1_in;
  wr_entry_t r_s1_entry;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_s1_valid <= 1'b0;
      r_s1_in    <= 1'b0;
      r_s1_entry <= '0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_in    <= w_in;
      r_s1_entry <= w_s0_entry;
    end
  end

  // Write-request FIFO
  wr_entry_t        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push, w_pop, w_nempty;
  wr_entry_t        w_head;

  assign w_nempty = (r_count != '0);
  assign w_push   = r_s1_valid && r_s1_in;
  assign w_pop    = w_nempty && vram_ack_i;
  assign w_head   = r_mem[r_rd_ptr];

  // NOTE: storage is left unreset; validity is tracked by the reset pointers and
  // count, and the outputs are gated while empty so stale words never leak out.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_s1_entry;
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Stage 1 never stalls, so it must always have a free FIFO slot reserved.
  localparam logic [CNT_W:0] L_DEPTH = (CNT_W + 1)'(FIFO_DEPTH);
  logic [CNT_W:0] w_occupancy;

  assign w_occupancy = {1'b0, r_count} + {{CNT_W{1'b0}}, r_s1_valid};
  assign pix_ready_o = (w_occupancy < L_DEPTH);

  // Primitive completion and clip statistics
  logic        r_last_pending;
  logic [15:0] r_clip_count;
  logic        w_done;

  assign w_done = r_last_pending && !r_s1_valid && !w_nempty;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_last_pending <= 1'b0;
    end else if (w_accept && pix_last_i) begin
      r_last_pending <= 1'b1;
    end else if (w_done) begin
      r_last_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_clip_count <= '0;
    end else if (cmd_valid_i && (w_op == OP_CLR_STATS)) begin
      r_clip_count <= '0;
    end else if (r_s1_valid && !r_s1_in && (r_clip_count != 16'hFFFF)) begin
      r_clip_count <= r_clip_count + 16'd1;
    end
  end

  assign vram_sel_o   = w_nempty;
  assign vram_wr_o    = w_nempty;
  assign vram_mask_o  = w_nempty ? w_head.mask : '0;
  assign vram_addr_o  = w_nempty ? w_head.addr : '0;
  assign vram_data_o  = w_nempty ? w_head.data : '0;
  assign busy_o       = r_s1_valid || w_nempty || r_last_pending;
  assign done_o       = w_done;
  assign clip_count_o = r_clip_count;

endmodule

// File: tb/tb_prim_pixel_writer.sv
// Self-checking bench for prim_pixel_writer: directed scenarios plus randomized traffic,
// all compared against a behavioural model of the clip/address rules.
module tb_prim_pixel_writer;

  logic               clk = 1'b0;
  logic               reset_i;
  logic [15:0]        cmd_i;
  logic               cmd_valid_i;
  logic               pix_valid_i;
  logic               pix_ready_o;
  logic signed [11:0] pix_x_i, pix_y_i;
  logic               pix_last_i;
  logic               vram_sel_o, vram_wr_o;
  logic [3:0]         vram_mask_o;
  logic [15:0]        vram_addr_o, vram_data_o;
  logic               vram_ack_i;
  logic               busy_o, done_o;
  logic [15:0]        clip_count_o;

  always #5 clk = ~clk;

  prim_pixel_writer dut (
    .clk(clk), .reset_i(reset_i), .cmd_i(cmd_i), .cmd_valid_i(cmd_valid_i),
    .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o), .pix_x_i(pix_x_i),
    .pix_y_i(pix_y_i), .pix_last_i(pix_last_i), .vram_sel_o(vram_sel_o),
    .vram_wr_o(vram_wr_o), .vram_mask_o(vram_mask_o), .vram_addr_o(vram_addr_o),
    .vram_data_o(vram_data_o), .vram_ack_i(vram_ack_i), .busy_o(busy_o),
    .done_o(done_o), .clip_count_o(clip_count_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;

  // Outputs sampled mid-cycle by step()
  logic        s_ready, s_wr, s_sel, s_busy, s_done, s_acc;
  logic [3:0]  s_mask;
  logic [15:0] s_addr, s_data, s_clip;

  logic [35:0] obs_q[$];
  logic [35:0] exp_q[$];
  int          obs_cyc[$];

  // Reference model state
  int m_x0, m_y0, m_x1, m_y1, m_color, m_stride, m_base, m_mode8, m_clip;
  bit m_pend;

  task automatic model_reset();
    m_x0 = 0; m_y0 = 0; m_x1 = 319; m_y1 = 239;
    m_color = 0; m_stride = 160; m_base = 0; m_mode8 = 1;
    m_clip = 0; m_pend = 0;
    exp_q.delete();
  endtask

  task automatic model_pixel(input int x, input int y);
    int a, mk, d;
    if (x >= m_x0 && x <= m_x1 && y >= m_y0 && y <= m_y1) begin
      a  = (m_base + y * m_stride + (m_mode8 != 0 ? x / 2 : x / 4)) & 32'hFFFF;
      mk = (m_mode8 != 0) ? ((x % 2 == 1) ? 3 : 12) : (8 >> (x % 4));
      d  = (m_mode8 != 0) ? m_color * 257 : (m_color & 15) * 4369;
      exp_q.push_back({a[15:0], mk[3:0], d[15:0]});
    end else begin
      m_pend = 1;
    end
  endtask

  task automatic model_cmd(input logic [3:0] op, input logic [11:0] p);
    int sp;
    sp = $signed(p);
    case (op)
      4'd0: m_x0 = sp;
      4'd1: m_y0 = sp;
      4'd2: m_x1 = sp;
      4'd3: m_y1 = sp;
      4'd4: m_color = int'(p[7:0]);
      4'd5: m_stride = int'(p);
      4'd6: m_base = (m_base & 32'hFF00) | int'(p[7:0]);
      4'd7: m_base = (m_base & 32'h00FF) | (int'(p[7:0]) << 8);
      4'd8: m_mode8 = int'(p[0]);
      4'd9: m_clip = 0;
      default: ;
    endcase
  endtask

  // One clock cycle: sample at negedge, update the model, advance past posedge.
  task automatic step();
    @(negedge clk);
    s_ready = pix_ready_o; s_wr = vram_wr_o; s_sel = vram_sel_o; s_busy = busy_o;
    s_done = done_o; s_mask = vram_mask_o; s_addr = vram_addr_o; s_data = vram_data_o;
    s_clip = clip_count_o; s_acc = pix_valid_i && pix_ready_o;
    if (done_o) done_cnt++;
    if (vram_wr_o && vram_ack_i) begin
      obs_q.push_back({vram_addr_o, vram_mask_o, vram_data_o});
      obs_cyc.push_back(cyc);
    end
    if (reset_i) begin
      model_reset();
    end else begin
      if (m_pend) begin
        if (m_clip < 65535) m_clip++;
        m_pend = 0;
      end
      if (s_acc) model_pixel(int'($signed(pix_x_i)), int'($signed(pix_y_i)));
      if (cmd_valid_i) model_cmd(cmd_i[15:12], cmd_i[11:0]);
    end
    @(posedge clk);
    #1;
    cyc++;
    cmd_valid_i = 1'b0;
  endtask

  task automatic cmd(input logic [3:0] op, input logic [11:0] p);
    cmd_i = {op, p};
    cmd_valid_i = 1'b1;
    step();
  endtask

  task automatic send(input int x, input int y, input bit last);
    pix_x_i = 12'(x); pix_y_i = 12'(y); pix_last_i = last; pix_valid_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (s_acc) break;
    end
    pix_valid_i = 1'b0; pix_last_i = 1'b0;
    checks++;
    if (!s_acc) begin errors++; $display("FAIL send_accept: pixel (%0d,%0d) not accepted within 200 cycles", x, y); end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin step(); n++; end while (s_busy && n < 300);
    checks++;
    if (s_busy) begin errors++; $display("FAIL wait_idle: busy_o=%0b after %0d cycles, want 0", s_busy, n); end
  endtask

  task automatic clear_q();
    obs_q.delete(); exp_q.delete(); obs_cyc.delete();
  endtask

  task automatic set_clip(input int x0, input int y0, input int x1, input int y1);
    cmd(4'd0, 12'(x0)); cmd(4'd1, 12'(y0)); cmd(4'd2, 12'(x1)); cmd(4'd3, 12'(y1));
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    step(); step();
    reset_i = 1'b0;
    step();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b want 1", s_ready); end
    checks++; if (s_wr !== 1'b0 || s_sel !== 1'b0) begin errors++; $display("FAIL rst_wr_sel: got %0b/%0b want 0/0", s_wr, s_sel); end
    checks++; if ({s_addr, s_mask, s_data} !== 36'h0) begin errors++; $display("FAIL rst_bus: got %0h want 0", {s_addr, s_mask, s_data}); end
    checks++; if (s_busy !== 1'b0 || s_done !== 1'b0) begin errors++; $display("FAIL rst_busy_done: got %0b/%0b want 0/0", s_busy, s_done); end
    checks++; if (s_clip !== 16'h0) begin errors++; $display("FAIL rst_clip: got %0h want 0", s_clip); end
  endtask

  task automatic test_basic_8bpp();
    cmd(4'd6, 12'h000); cmd(4'd7, 12'h010); cmd(4'd5, 12'd160);
    cmd(4'd4, 12'h05A); cmd(4'd8, 12'h001);
    clear_q();
    vram_ack_i = 1'b1;
    pix_x_i = 12'sd3; pix_y_i = 12'sd2; pix_last_i = 1'b1; pix_valid_i = 1'b1;
    step();                                  // N
    pix_valid_i = 1'b0; pix_last_i = 1'b0;
    checks++; if (s_acc !== 1'b1) begin errors++; $display("FAIL basic_accept: got %0b want 1", s_acc); end
    step();                                  // N+1
    checks++; if (s_wr !== 1'b0) begin errors++; $display("FAIL basic_wr_n1: got %0b want 0", s_wr); end
    step();                                  // N+2
    checks++; if (s_wr !== 1'b1) begin errors++; $display("FAIL basic_wr_n2: got %0b want 1", s_wr); end
    checks++; if ({s_addr, s_mask, s_data} !== {16'h1141, 4'b0011, 16'h5A5A}) begin
      errors++; $display("FAIL basic_word: got %0h want %0h", {s_addr, s_mask, s_data}, {16'h1141, 4'b0011, 16'h5A5A}); end
    step();                                  // N+3
    checks++; if (s_wr !== 1'b0 || s_done !== 1'b1 || s_busy !== 1'b1) begin
      errors++; $display("FAIL basic_done_n3: wr/done/busy got %0b/%0b/%0b want 0/1/1", s_wr, s_done, s_busy); end
    step();                                  // N+4
    checks++; if (s_busy !== 1'b0 || s_done !== 1'b0) begin
      errors++; $display("FAIL basic_idle_n4: busy/done got %0b/%0b want 0/0", s_busy, s_done); end
  endtask

  task automatic test_4bpp();
    logic [35:0] want;
    int          mk;
    cmd(4'd8, 12'h000); cmd(4'd4, 12'h007);
    clear_q();
    vram_ack_i = 1'b1;
    for (int x = 0; x < 4; x++) send(x, 0, x == 3);
    wait_idle();
    checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL b4_count: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 4; i++) begin
      mk = 8 >> i;
      want = {16'h1000, mk[3:0], 16'h7777};
      checks++; if (obs_q[i] !== want) begin errors++; $display("FAIL b4_word%0d: got %0h want %0h", i, obs_q[i], want); end
    end
  endtask

  task automatic test_clip();
    int d0;
    cmd(4'd8, 12'h001); cmd(4'd9, 12'h000);
    set_clip(10, 10, 20, 20);
    clear_q();
    d0 = done_cnt;
    send(9, 10, 0); send(10, 10, 0); send(21, 20, 0); send(-1, 15, 1);
    wait_idle();
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL clip_count_w: got %0d want 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      checks++; if (obs_q[0] !== {16'h1645, 4'b1100, 16'h0707}) begin
        errors++; $display("FAIL clip_word: got %0h want %0h", obs_q[0], {16'h1645, 4'b1100, 16'h0707}); end
    end
    checks++; if (s_clip !== 16'd3) begin errors++; $display("FAIL clip_stat: got %0d want 3", s_clip); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL clip_done: got %0d pulses want 1", done_cnt - d0); end
    cmd(4'd9, 12'h000);
    step();
    checks++; if (s_clip !== 16'd0) begin errors++; $display("FAIL clip_clr: got %0d want 0", s_clip); end
    // Clear arriving as the clipped pixel reaches stage 1 must win.
    send(0, 0, 0);
    cmd(4'd9, 12'h000);
    step();
    checks++; if (s_clip !== 16'd0) begin errors++; $display("FAIL clip_clr_wins: got %0d want 0", s_clip); end
    send(0, 0, 0);
    step(); step();
    checks++; if (s_clip !== 16'(m_clip) || m_clip != 1) begin errors++; $display("FAIL clip_inc: got %0d want 1", s_clip); end
  endtask

  task automatic test_stride();
    set_clip(0, 0, 2047, 2047);
    cmd(4'd7, 12'h000); cmd(4'd5, 12'd160);
    clear_q();
    vram_ack_i = 1'b1;
    cmd_i = {4'd5, 12'd100}; cmd_valid_i = 1'b1;
    send(4, 3, 0);
    send(4, 3, 0);
    wait_idle();
    checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL stride_count: got %0d want 2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      checks++; if (obs_q[0][35:20] !== 16'd482) begin errors++; $display("FAIL stride_old: got %0d want 482", obs_q[0][35:20]); end
      checks++; if (obs_q[1][35:20] !== 16'd302) begin errors++; $display("FAIL stride_new: got %0d want 302", obs_q[1][35:20]); end
    end
    cmd(4'd5, 12'd160);
  endtask

  task automatic test_back_to_back();
    int a0;
    clear_q();
    vram_ack_i = 1'b1;
    send(0, 7, 0);
    a0 = cyc - 1;
    for (int i = 1; i < 6; i++) send(i * 2, 7, i == 5);
    wait_idle();
    checks++; if (obs_q.size() != exp_q.size() || obs_q.size() != 6) begin
      errors++; $display("FAIL b2b_count: got %0d want 6 (model %0d)", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_word%0d: got %0h want %0h", i, obs_q[i], exp_q[i]); end
      checks++; if (obs_cyc[i] !== a0 + 2 + i) begin errors++; $display("FAIL b2b_cycle%0d: got %0d want %0d", i, obs_cyc[i], a0 + 2 + i); end
    end
  endtask

  task automatic test_backpressure();
    int          acc = 0;
    logic [15:0] h;
    bit          stable = 1;
    clear_q();
    vram_ack_i = 1'b0;
    for (int c = 0; c < 12; c++) begin
      pix_x_i = 12'(acc + 20); pix_y_i = 12'sd4; pix_valid_i = (acc < 8);
      step();
      if (s_acc) acc++;
    end
    checks++; if (acc !== 4) begin errors++; $display("FAIL bp_accepted: got %0d want 4", acc); end
    checks++; if (s_ready !== 1'b0 || s_wr !== 1'b1) begin errors++; $display("FAIL bp_ready_wr: got %0b/%0b want 0/1", s_ready, s_wr); end
    h = s_addr;
    for (int c = 0; c < 4; c++) begin
      step();
      if (s_addr !== h || s_wr !== 1'b1 || s_acc) stable = 0;
    end
    checks++; if (!stable) begin errors++; $display("FAIL bp_head_stable: got %0h want %0h held", s_addr, h); end
    checks++; if (exp_q.size() == 0 || h !== exp_q[0][35:20]) begin errors++; $display("FAIL bp_head_addr: got %0h want first pixel word", h); end
    vram_ack_i = 1'b1;
    for (int c = 0; c < 60 && acc < 8; c++) begin
      pix_x_i = 12'(acc + 20); pix_y_i = 12'sd4; pix_valid_i = 1'b1;
      step();
      if (s_acc) acc++;
    end
    pix_valid_i = 1'b0;
    wait_idle();
    checks++; if (obs_q.size() != 8 || exp_q.size() != 8) begin
      errors++; $display("FAIL bp_count: got %0d want 8 (model %0d)", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word%0d: got %0h want %0h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int          d0;
    logic [3:0]  op;
    logic [11:0] p;
    clear_q();
    d0 = done_cnt;
    for (int c = 0; c < 500; c++) begin
      op = 4'($urandom_range(0, 15));
      case (op)
        4'd0, 4'd1: p = 12'($urandom_range(0, 40) - 8);
        4'd2, 4'd3: p = 12'($urandom_range(150, 400));
        default:    p = 12'($urandom());
      endcase
      cmd_i       = {op, p};
      cmd_valid_i = ($urandom_range(0, 7) == 0);
      pix_valid_i = ($urandom_range(0, 3) != 0);
      pix_x_i     = 12'($urandom_range(0, 420) - 30);
      pix_y_i     = 12'($urandom_range(0, 300) - 30);
      vram_ack_i  = ($urandom_range(0, 2) != 0);
      step();
    end
    pix_valid_i = 1'b0;
    vram_ack_i  = 1'b1;
    send(5, 5, 1);
    wait_idle();
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_word%0d: got %0h want %0h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (s_clip !== 16'(m_clip)) begin errors++; $display("FAIL rnd_clip: got %0d want %0d", s_clip, m_clip); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rnd_done: got %0d pulses want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int d0;
    set_clip(0, 0, 2047, 2047);
    clear_q();
    vram_ack_i = 1'b0;
    send(5, 5, 0); send(6, 5, 0); send(7, 5, 1);
    step(); step();
    checks++; if (s_wr !== 1'b1 || s_busy !== 1'b1) begin errors++; $display("FAIL rm_loaded: wr/busy got %0b/%0b want 1/1", s_wr, s_busy); end
    d0 = done_cnt;
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    step();
    checks++; if (s_wr !== 1'b0 || s_sel !== 1'b0) begin errors++; $display("FAIL rm_wr_sel: got %0b/%0b want 0/0", s_wr, s_sel); end
    checks++; if ({s_addr, s_mask, s_data} !== 36'h0) begin errors++; $display("FAIL rm_bus: got %0h want 0", {s_addr, s_mask, s_data}); end
    checks++; if (s_busy !== 1'b0 || s_done !== 1'b0) begin errors++; $display("FAIL rm_busy_done: got %0b/%0b want 0/0", s_busy, s_done); end
    checks++; if (s_ready !== 1'b1 || s_clip !== 16'h0) begin errors++; $display("FAIL rm_ready_clip: got %0b/%0d want 1/0", s_ready, s_clip); end
    repeat (4) step();
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL rm_no_done: got %0d pulses want 0", done_cnt - d0); end
    clear_q();
    vram_ack_i = 1'b1;
    send(3, 2, 0);
    send(320, 0, 1);
    wait_idle();
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL rm_cfg_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      checks++; if (obs_q[0] !== {16'd321, 4'b0011, 16'h0000}) begin
        errors++; $display("FAIL rm_cfg_word: got %0h want %0h", obs_q[0], {16'd321, 4'b0011, 16'h0000}); end
    end
    checks++; if (s_clip !== 16'd1) begin errors++; $display("FAIL rm_cfg_clip: got %0d want 1", s_clip); end
  endtask

  initial begin
    reset_i = 1'b1; cmd_i = '0; cmd_valid_i = 1'b0; pix_valid_i = 1'b0;
    pix_x_i = '0; pix_y_i = '0; pix_last_i = 1'b0; vram_ack_i = 1'b0;
    model_reset();
    test_reset();
    test_basic_8bpp();
    test_4bpp();
    test_clip();
    test_stride();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prim_pixel_writer.md
Name: prim_pixel_writer

Overview:
Parametrised back end for the primitive renderer. It accepts an (x,y) pixel stream from the draw engines (line, filled rectangle, later triangle) over a valid/ready handshake. Each pixel is clipped against a programmable rectangle and converted to a VRAM word address, nibble mask and data word for either 4 bpp or 8 bpp mode. Write requests are buffered in a FIFO and issued to the VRAM arbiter with an ack handshake, so the draw engines stall instead of dropping pixels when VRAM is busy.

Parameters:
CORDW, 12, signed coordinate width (pix_x_i, pix_y_i, clip registers)
FIFO_DEPTH, 4, write-request FIFO entries; power of 2, >=2
ADDR_W, 16, VRAM word address width
RST_CLIP_W, 320, reset clip x1 = RST_CLIP_W-1
RST_CLIP_H, 240, reset clip y1 = RST_CLIP_H-1
RST_STRIDE, 160, reset line stride in VRAM words

Ports:
clk  in  1  system clock
reset_i  in  1  synchronous active-high reset
cmd_i  in  16  config command: [15:12] opcode, [11:0] payload
cmd_valid_i  in  1  cmd_i valid this cycle
pix_valid_i  in  1  pixel present
pix_ready_o  out  1  pixel accepted when valid&&ready
pix_x_i  in  CORDW  signed x
pix_y_i  in  CORDW  signed y
pix_last_i  in  1  final pixel of the primitive
vram_sel_o  out  1  VRAM select
vram_wr_o  out  1  VRAM write request
vram_mask_o  out  4  nibble write mask
vram_addr_o  out  ADDR_W  word address
vram_data_o  out  16  write data
vram_ack_i  in  1  arbiter accepted current request
busy_o  out  1  pixels in flight or done pending
done_o  out  1  one-cycle pulse: primitive fully retired
clip_count_o  out  16  saturating count of clipped pixels

Behaviour:
- Opcodes (all others ignored):
  - 0 CLIP_X0, 1 CLIP_Y0, 2 CLIP_X1, 3 CLIP_Y1: payload signed, CORDW bits.
  - 4 COLOR: payload[7:0].
  - 5 STRIDE: payload[11:0], zero-extended.
  - 6 BASE_LO: base[7:0] = payload[7:0].
  - 7 BASE_HI: base[15:8] = payload[7:0].
  - 8 MODE: bit0 = 1 for 8 bpp, 0 for 4 bpp.
  - 9 CLR_STATS: clip_count cleared to 0.
- A command in cycle N affects pixels accepted from N+1 onward. A pixel accepted in cycle N uses the config as it stood in N.
- Reset values:
  - All outputs 0, except pix_ready_o = 1 in the first cycle after reset.
  - Config: clip = (0, 0, RST_CLIP_W-1, RST_CLIP_H-1), color 0, stride RST_STRIDE, base 0, mode 8 bpp.
  - FIFO, stage 1, last_pending and clip_count cleared.
- Reset mid-operation flushes everything in flight; no done_o is produced.
- Stage 0 (acceptance cycle N), computed combinationally from the pixel inputs and config, then registered into stage 1:
  - in = (x0<=x<=x1) && (y0<=y<=y1), signed and inclusive.
  - 8 bpp: addr = base + y*stride + (x>>1); mask = x[0] ? 4'b0011 : 4'b1100; data = {color, color}.
  - 4 bpp: addr = base + y*stride + (x>>2); mask = 4'b1000 >> x[1:0]; data = {4{color[3:0]}}.
  - Address arithmetic is modulo 2^ADDR_W. y and x are non-negative whenever in = 1.
- Stage 1 (cycle N+1):
  - If in, push the entry to the FIFO.
  - Else drop it and increment clip_count, saturating at 16'hFFFF.
  - If CLR_STATS coincides with a clipped-pixel increment, clear wins.
- Flow control: pix_ready_o = (fifo_count + s1_valid) < FIFO_DEPTH, derived from registers only. Stage 1 never stalls.
- Output:
  - vram_sel_o = vram_wr_o = FIFO non-empty, presenting the FIFO head on mask/addr/data.
  - The head pops in the cycle where vram_wr_o && vram_ack_i.
  - The head is stable while unacked; the arbiter may hold ack low indefinitely.
  - Minimum latency: accept at N -> vram_wr_o high at N+2.
  - One write per cycle with continuous ack.
- The FIFO may push and pop in the same cycle; count is unchanged.
- last_pending:
  - Set when a pixel with pix_last_i is accepted.
  - done_o pulses in the first cycle where last_pending=1, s1_valid=0 and the FIFO is empty; last_pending clears in that same cycle.
  - A clipped last pixel still produces done_o.
  - A new primitive may be accepted before done_o. last_pending is a single flag, so engines must not issue a second last pixel before done_o.
- busy_o = s1_valid | fifo non-empty | last_pending.

Test Plan:
- 8 bpp, base 0x1000, stride 160, color 0x5A; pixel (3,2,last), ack tied 1 -> N+2: addr 0x1141, mask 0011, data 0x5A5A, wr for 1 cycle; done_o pulses at N+3; busy_o drops at N+4.
- MODE=4 bpp, color 0x7; pixels x=0..3 at y=0 -> masks 1000, 0100, 0010, 0001, all at addr base+0, data 0x7777.
- Clip set to (10,10)-(20,20); send (9,10), (10,10), (21,20), (-1,15) with last on the final pixel -> only (10,10) written; clip_count=3; done_o still pulses; CLR_STATS -> 0.
- Ack held low, stream 8 pixels -> exactly FIFO_DEPTH writes queued; pix_ready_o low once fifo_count+s1_valid=4; head addr stable while unacked; release ack -> all 8 written in order, none lost.
- STRIDE command in the same cycle as an accepted pixel -> that pixel uses the old stride, the next pixel uses the new one.
- Assert reset_i with 3 entries queued and last_pending set -> next cycle all outputs 0, busy_o 0, config at defaults, no done_o.
